// File: rtl/pong_match_ctl.sv
// +--------------------------------------------------------------------------+
// | pong_match_ctl : match sequencer for the wall PONG game (serve delay,    |
// | ball release, exit detection, scoring, winner declaration).              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pong_match_ctl #(
  parameter int unsigned SCREEN_W    = 1024,
  parameter int unsigned SERVE_DELAY = 65_000_000,
  parameter int unsigned WIN_SCORE   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] ball_xpos,
  output logic        ball_rst,
  output logic [2:0]  state,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [1:0]  winner,
  output logic        point_pulse
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    SERVE = 3'b001,
    RALLY = 3'b010,
    POINT = 3'b011,
    OVER  = 3'b100
  } state_t;

  localparam logic [26:0] C_SERVE_LAST = 27'(SERVE_DELAY - 1);
  localparam logic [11:0] C_SCREEN_W   = 12'(SCREEN_W);
  localparam logic [3:0]  C_WIN        = 4'(WIN_SCORE);

  state_t      state_q;
  logic [26:0] timer_q;
  logic        start_q;
  logic [3:0]  score_l_q;
  logic [3:0]  score_r_q;
  logic [1:0]  winner_q;
  logic        point_pulse_q;

  logic        w_start_edge;
  logic        w_exit_left;
  logic        w_exit_right;
  logic [3:0]  w_score_l_inc;
  logic [3:0]  w_score_r_inc;

  assign w_start_edge  = start & ~start_q;
  assign w_exit_left   = (ball_xpos == 11'd0);
  assign w_exit_right  = ({1'b0, ball_xpos} >= C_SCREEN_W);
  // Saturating increments: a score of 15 never wraps back to 0.
  assign w_score_l_inc = score_l_q + {3'b000, (score_l_q != 4'hF)};
  assign w_score_r_inc = score_r_q + {3'b000, (score_r_q != 4'hF)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      start_q       <= 1'b0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      winner_q      <= 2'b00;
      point_pulse_q <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        IDLE, OVER: begin
          if (w_start_edge) begin
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 2'b00;
            timer_q   <= '0;
            state_q   <= SERVE;
          end
        end
        SERVE: begin
          if (timer_q == C_SERVE_LAST) begin
            timer_q <= '0;
            state_q <= RALLY;
          end else begin
            timer_q <= timer_q + 27'd1;
          end
        end
        RALLY: begin
          if (w_exit_left) begin
            score_r_q     <= w_score_r_inc;
            point_pulse_q <= 1'b1;
            state_q       <= POINT;
          end else if (w_exit_right) begin
            score_l_q     <= w_score_l_inc;
            point_pulse_q <= 1'b1;
            state_q       <= POINT;
          end
        end
        POINT: begin
          point_pulse_q <= 1'b0;
          timer_q       <= '0;
          if (score_l_q == C_WIN) begin
            winner_q <= 2'b01;
            state_q  <= OVER;
          end else if (score_r_q == C_WIN) begin
            winner_q <= 2'b10;
            state_q  <= OVER;
          end else begin
            state_q <= SERVE;
          end
        end
        default: begin
          point_pulse_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  // The ball controller only runs free during a rally.
  assign ball_rst    = (state_q != RALLY);
  assign state       = state_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign winner      = winner_q;
  assign point_pulse = point_pulse_q;

endmodule

`default_nettype wire
